// File: rtl/sort_loader.sv
// Stream-to-vector front end for the bitonic sorter: packs beats into a SIZE-wide
// vector, pads short packets, and delays valid/count to line up with the sorter output.
module sort_loader #(
    parameter int unsigned VALUE_BITS = 8,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned DIRECTION  = 0,
    parameter int unsigned LATENCY    = DEPTH * (DEPTH + 1) / 2,
    parameter int unsigned SIZE       = 1 << DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [VALUE_BITS-1:0]        in_data,
    input  logic                         in_last,
    output logic                         vec_valid,
    output logic [SIZE*VALUE_BITS-1:0]   vec_data,
    output logic [DEPTH:0]               vec_count,
    output logic                         done_valid,
    output logic [DEPTH:0]               done_count
);

    localparam int unsigned CNT_W = DEPTH + 1;
    localparam logic [VALUE_BITS-1:0] PAD = (DIRECTION == 0) ? {VALUE_BITS{1'b1}} : '0;

    logic [DEPTH-1:0]       r_idx;
    logic [VALUE_BITS-1:0]  r_fill [SIZE];
    logic                   r_dly_valid [LATENCY];
    logic [DEPTH:0]         r_dly_count [LATENCY];

    logic                      w_beat;
    logic                      w_final;
    logic [SIZE*VALUE_BITS-1:0] w_vec;

    assign w_beat  = in_valid & in_ready;
    assign w_final = w_beat & ((r_idx == DEPTH'(SIZE - 1)) | in_last);

    // Completed vector: stored slots below idx, this beat at idx, pad above.
    always_comb begin
        w_vec = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (DEPTH'(i) < r_idx) begin
                w_vec[i*VALUE_BITS +: VALUE_BITS] = r_fill[i];
            end else if (DEPTH'(i) == r_idx) begin
                w_vec[i*VALUE_BITS +: VALUE_BITS] = in_data;
            end else begin
                w_vec[i*VALUE_BITS +: VALUE_BITS] = PAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b0;
            r_idx     <= '0;
            vec_valid <= 1'b0;
            vec_data  <= '0;
            vec_count <= '0;
            for (int i = 0; i < SIZE; i++) begin
                r_fill[i] <= '0;
            end
        end else begin
            in_ready  <= 1'b1;
            vec_valid <= 1'b0;
            if (w_final) begin
                vec_valid <= 1'b1;
                vec_data  <= w_vec;
                vec_count <= {1'b0, r_idx} + CNT_W'(1);
                r_idx     <= '0;
            end else if (w_beat) begin
                r_fill[r_idx] <= in_data;
                r_idx         <= r_idx + DEPTH'(1);
            end
        end
    end

    // Delay line tracking which sorter output cycle carries a real vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_dly_valid[i] <= 1'b0;
                r_dly_count[i] <= '0;
            end
        end else begin
            r_dly_valid[0] <= vec_valid;
            r_dly_count[0] <= vec_count;
            for (int i = 1; i < LATENCY; i++) begin
                r_dly_valid[i] <= r_dly_valid[i-1];
                r_dly_count[i] <= r_dly_count[i-1];
            end
        end
    end

    assign done_valid = r_dly_valid[LATENCY-1];
    assign done_count = r_dly_count[LATENCY-1];

endmodule

// File: tb/tb_sort_loader.sv
// Self-checking bench for sort_loader: directed packets then random traffic against a
// packet-level reference model, for both pad directions.
module tb_sort_loader;

    localparam int unsigned VB = 8;
    localparam int unsigned D  = 2;
    localparam int unsigned L  = 3;
    localparam int unsigned S  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [VB-1:0] in_data;
    logic          in_last;

    logic          rdy0, rdy1, vv0, vv1, dv0, dv1;
    logic [S*VB-1:0] vd0, vd1;
    logic [D:0]    vc0, vc1, dc0, dc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sort_loader #(.VALUE_BITS(VB), .DEPTH(D), .DIRECTION(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_last(in_last), .vec_valid(vv0), .vec_data(vd0),
        .vec_count(vc0), .done_valid(dv0), .done_count(dc0)
    );

    sort_loader #(.VALUE_BITS(VB), .DEPTH(D), .DIRECTION(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_last(in_last), .vec_valid(vv1), .vec_data(vd1),
        .vec_count(vc1), .done_valid(dv1), .done_count(dc1)
    );

    // Reference model state
    logic [VB-1:0]   pkt[$];
    logic [S*VB-1:0] m_data0 = '0;
    logic [S*VB-1:0] m_data1 = '0;
    logic [D:0]      m_cnt = '0;
    logic            m_vv = 1'b0;
    logic            m_rdy = 1'b0;
    logic            hist_v [4096];
    logic [D:0]      hist_c [4096];
    int              cyc = 0;
    int              last_rst = 0;
    int              pulses = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [VB-1:0] d, input logic l);
        logic       e_dv;
        logic [D:0] e_dc;
        rst = r; in_valid = v; in_data = d; in_last = l;
        @(posedge clk);
        #1;
        cyc++;
        m_vv = 1'b0;
        if (r) begin
            pkt.delete();
            m_data0 = '0; m_data1 = '0; m_cnt = '0;
            last_rst = cyc;
        end else if (v && m_rdy) begin
            pkt.push_back(d);
            if (pkt.size() == S || l) begin
                for (int k = 0; k < S; k++) begin
                    m_data0[k*VB +: VB] = (k < pkt.size()) ? pkt[k] : 8'hFF;
                    m_data1[k*VB +: VB] = (k < pkt.size()) ? pkt[k] : 8'h00;
                end
                m_cnt = (D+1)'(pkt.size());
                m_vv  = 1'b1;
                pulses++;
                pkt.delete();
            end
        end
        m_rdy = !r;
        hist_v[cyc] = m_vv;
        hist_c[cyc] = m_cnt;
        if (cyc >= last_rst + int'(L)) begin
            e_dv = hist_v[cyc-L];
            e_dc = hist_c[cyc-L];
        end else begin
            e_dv = 1'b0;
            e_dc = '0;
        end
        check("in_ready0", 64'(rdy0), 64'(m_rdy));
        check("in_ready1", 64'(rdy1), 64'(m_rdy));
        check("vec_valid0", 64'(vv0), 64'(m_vv));
        check("vec_valid1", 64'(vv1), 64'(m_vv));
        check("vec_data0", 64'(vd0), 64'(m_data0));
        check("vec_data1", 64'(vd1), 64'(m_data1));
        check("vec_count0", 64'(vc0), 64'(m_cnt));
        check("vec_count1", 64'(vc1), 64'(m_cnt));
        check("done_valid0", 64'(dv0), 64'(e_dv));
        check("done_valid1", 64'(dv1), 64'(e_dv));
        check("done_count0", 64'(dc0), 64'(e_dc));
        check("done_count1", 64'(dc1), 64'(e_dc));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int p0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0);
        check("rst_ready", 64'(rdy0), 64'd0);
        check("rst_vec_data", 64'(vd0), 64'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // 1: four beats 7,3,9,1
        step(1'b0, 1'b1, 8'd7, 1'b0);
        step(1'b0, 1'b1, 8'd3, 1'b0);
        step(1'b0, 1'b1, 8'd9, 1'b0);
        step(1'b0, 1'b1, 8'd1, 1'b1);
        check("t1_data", 64'(vd0), 64'h01090307);
        check("t1_count", 64'(vc0), 64'd4);
        idle(2);
        check("t1_done_early", 64'(dv0), 64'd0);
        idle(1);
        check("t1_done", 64'(dv0), 64'd1);
        check("t1_done_count", 64'(dc0), 64'd4);
        idle(1);

        // 2/3: two beats 5,2 with last, both pad directions
        step(1'b0, 1'b1, 8'd5, 1'b0);
        step(1'b0, 1'b1, 8'd2, 1'b1);
        check("t2_data_asc", 64'(vd0), 64'hFFFF0205);
        check("t3_data_desc", 64'(vd1), 64'h00000205);
        check("t2_count", 64'(vc0), 64'd2);
        idle(1);
        check("t2_hold", 64'(vd0), 64'hFFFF0205);

        // 4: eight back-to-back beats
        p0 = pulses;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
        check("t4_pulses", 64'(pulses - p0), 64'd2);
        check("t4_data", 64'(vd0), 64'h17161514);
        idle(4);

        // 5: single beat with last
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        check("t5_data", 64'(vd0), 64'hFFFFFFA5);
        check("t5_count", 64'(vc0), 64'd1);

        // 6: reset mid-packet, with a vector still in the delay line
        step(1'b0, 1'b1, 8'h21, 1'b0);
        step(1'b0, 1'b1, 8'h22, 1'b0);
        step(1'b1, 1'b1, 8'h23, 1'b0);
        step(1'b1, 1'b1, 8'h24, 1'b1);
        check("t6_ready_low", 64'(rdy0), 64'd0);
        check("t6_done_clr", 64'(dv0), 64'd0);
        step(1'b0, 1'b1, 8'h99, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        check("t6_clean", 64'(vd0), 64'h33323130);
        idle(4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                 8'($urandom), ($urandom_range(0, 3) == 0));
        end
        idle(L + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
